// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_pkg
//  Purpose  : Shared helpers for the buffered 1R1W SRAM: expansion of a
//             per-word mask into a per-bit mask, and word-granular merge.
//  Revision : 1.0 - initial release
// ============================================================================
package sram_pkg;

    // Upper bounds for the helper functions; callers cast to their own widths.
    localparam int MAX_WIDTH  = 1024;
    localparam int MAX_WORDS  = 64;
    localparam int WORD_IDX_W = $clog2(MAX_WORDS);

    // Replicate each mask bit across the WORD_SIZE bits of the word it covers.
    function automatic logic [MAX_WIDTH-1:0] expand_valid(
        input logic [MAX_WORDS-1:0] bits,
        input int unsigned          word_size
    );
        logic [MAX_WIDTH-1:0] mask;
        int unsigned          word;
        mask = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            word = i / word_size;
            if (word < MAX_WORDS) begin
                mask[i] = bits[WORD_IDX_W'(word)];
            end
        end
        return mask;
    endfunction

    // Take each word from new_row where en is set, otherwise from old_row.
    function automatic logic [MAX_WIDTH-1:0] word_merge(
        input logic [MAX_WIDTH-1:0] old_row,
        input logic [MAX_WIDTH-1:0] new_row,
        input logic [MAX_WORDS-1:0] en,
        input int unsigned          word_size
    );
        logic [MAX_WIDTH-1:0] mask;
        mask = expand_valid(en, word_size);
        return (old_row & ~mask) | (new_row & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_valid_table.sv
`default_nettype none
// ============================================================================
//  Module   : sram_valid_table
//  Purpose  : One valid flop per (row, word). Cleared in a single cycle by
//             reset, set by writes, read combinationally.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_valid_table
    import sram_pkg::*;
#(
    parameter int LOG_NUM_ROWS = 9,
    parameter int NUM_WORDS    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_valid,
    input  logic [LOG_NUM_ROWS-1:0] wr_addr,
    input  logic [NUM_WORDS-1:0]    wr_en,
    input  logic [LOG_NUM_ROWS-1:0] rd_addr,
    output logic [NUM_WORDS-1:0]    rd_bits
);

    localparam int NUM_ROWS = 2 ** LOG_NUM_ROWS;

    logic [NUM_WORDS-1:0] valid_bits [NUM_ROWS];

    // Whole-table clear on reset; otherwise accumulate the enabled words of each write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                valid_bits[r] <= '0;
            end
        end else if (wr_valid) begin
            valid_bits[wr_addr] <= valid_bits[wr_addr] | wr_en;
        end
    end

    assign rd_bits = valid_bits[rd_addr];

endmodule
`default_nettype wire

// File: rtl/sram_1r1w_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : sram_1r1w_buffered
//  Purpose  : 1R1W SRAM with valid/ready read port and a one-entry response
//             register, per-word write enables, write-first same-row bypass
//             and a single-cycle logical reset through per-word valid bits.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_1r1w_buffered
    import sram_pkg::*;
#(
    parameter int WIDTH        = 512,
    parameter int LOG_NUM_ROWS = 9,
    parameter int WORD_SIZE    = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rd_req_valid,
    output logic                          rd_req_ready,
    input  logic [LOG_NUM_ROWS-1:0]       rd_addr,
    output logic                          rd_rsp_valid,
    input  logic                          rd_rsp_ready,
    output logic [WIDTH-1:0]              rd_rsp_data,
    input  logic                          wr_valid,
    input  logic [LOG_NUM_ROWS-1:0]       wr_addr,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic [WIDTH/WORD_SIZE-1:0]    wr_en
);

    localparam int NUM_WORDS = WIDTH / WORD_SIZE;
    localparam int NUM_ROWS  = 2 ** LOG_NUM_ROWS;

    generate
        if (WIDTH % WORD_SIZE != 0) begin : g_bad_word_size
            $error("sram_1r1w_buffered: WIDTH must be a multiple of WORD_SIZE");
        end
        if (WIDTH > MAX_WIDTH || NUM_WORDS > MAX_WORDS) begin : g_too_wide
            $error("sram_1r1w_buffered: WIDTH or NUM_WORDS exceeds sram_pkg limits");
        end
    endgenerate

    logic                 wr_fire;
    logic                 rd_fire;
    logic [NUM_WORDS-1:0] rd_valid_bits;
    logic [NUM_WORDS-1:0] bypass_en;
    logic [WIDTH-1:0]     rd_masked;
    logic [WIDTH-1:0]     rd_next;
    logic [WIDTH-1:0]     mem [NUM_ROWS];

    // Anything presented while reset is high is ignored.
    assign wr_fire      = wr_valid && !reset;
    assign rd_req_ready = !rd_rsp_valid || rd_rsp_ready;
    assign rd_fire      = rd_req_valid && rd_req_ready && !reset;

    sram_valid_table #(
        .LOG_NUM_ROWS (LOG_NUM_ROWS),
        .NUM_WORDS    (NUM_WORDS)
    ) u_valid_table (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_fire),
        .wr_addr  (wr_addr),
        .wr_en    (wr_en),
        .rd_addr  (rd_addr),
        .rd_bits  (rd_valid_bits)
    );

    // Word-lane writes into a plain array; never cleared so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                if (wr_en[w]) begin
                    mem[wr_addr][w*WORD_SIZE +: WORD_SIZE] <= wr_data[w*WORD_SIZE +: WORD_SIZE];
                end
            end
        end
    end

    // Read data: hide never-written words, then let a same-row write win per word.
    always_comb begin
        bypass_en = '0;
        if (wr_fire && (wr_addr == rd_addr)) begin
            bypass_en = wr_en;
        end
        rd_masked = mem[rd_addr] & WIDTH'(expand_valid(MAX_WORDS'(rd_valid_bits), WORD_SIZE));
        rd_next   = WIDTH'(word_merge(MAX_WIDTH'(rd_masked), MAX_WIDTH'(wr_data),
                                      MAX_WORDS'(bypass_en), WORD_SIZE));
    end

    // One-entry response register: load on accept, drain on consume, hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_rsp_valid <= 1'b0;
            rd_rsp_data  <= '0;
        end else if (rd_fire) begin
            rd_rsp_valid <= 1'b1;
            rd_rsp_data  <= rd_next;
        end else if (rd_rsp_ready) begin
            rd_rsp_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_1r1w_buffered.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sram_1r1w_buffered
//  Purpose  : Scoreboard bench for sram_1r1w_buffered with a row-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_1r1w_buffered;

    localparam int WIDTH        = 512;
    localparam int LOG_NUM_ROWS = 9;
    localparam int WORD_SIZE    = 64;
    localparam int NUM_WORDS    = WIDTH / WORD_SIZE;
    localparam int NUM_ROWS     = 2 ** LOG_NUM_ROWS;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    rd_req_valid = 1'b0;
    logic                    rd_req_ready;
    logic [LOG_NUM_ROWS-1:0] rd_addr = '0;
    logic                    rd_rsp_valid;
    logic                    rd_rsp_ready = 1'b0;
    logic [WIDTH-1:0]        rd_rsp_data;
    logic                    wr_valid = 1'b0;
    logic [LOG_NUM_ROWS-1:0] wr_addr = '0;
    logic [WIDTH-1:0]        wr_data = '0;
    logic [NUM_WORDS-1:0]    wr_en = '0;

    sram_1r1w_buffered #(
        .WIDTH        (WIDTH),
        .LOG_NUM_ROWS (LOG_NUM_ROWS),
        .WORD_SIZE    (WORD_SIZE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_addr      (rd_addr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_ready (rd_rsp_ready),
        .rd_rsp_data  (rd_rsp_data),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_en        (wr_en)
    );

    always #5 clk = ~clk;

    int total    = 0;
    int bad      = 0;
    int consumed = 0;
    bit mon_on   = 1'b0;

    // Model: what each row logically reads as (unwritten words are zero).
    logic [WIDTH-1:0] model_rows [NUM_ROWS];
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] mv;

    function automatic logic [WIDTH-1:0] apply_write(input logic [WIDTH-1:0] old_row,
                                                     input logic [WIDTH-1:0] data,
                                                     input logic [NUM_WORDS-1:0] en);
        logic [WIDTH-1:0] r;
        r = old_row;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (en[w]) r[w*WORD_SIZE +: WORD_SIZE] = data[w*WORD_SIZE +: WORD_SIZE];
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rand_row();
        logic [WIDTH-1:0] r;
        for (int k = 0; k < WIDTH / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // Reference model: sees the same inputs at each edge, decides acceptance itself.
    always @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_ROWS; r++) model_rows[r] = '0;
            exp_q.delete();
        end else begin
            if (rd_req_valid && (exp_q.size() == 0 || rd_rsp_ready)) begin
                mv = model_rows[rd_addr];
                if (wr_valid && wr_addr == rd_addr) mv = apply_write(mv, wr_data, wr_en);
                exp_q.push_back(mv);
            end
            if (wr_valid) model_rows[wr_addr] = apply_write(model_rows[wr_addr], wr_data, wr_en);
        end
    end

    // Monitor: compares handshake and presented data, pops on consumption.
    always @(negedge clk) begin
        if (mon_on) begin
            check_bit("rsp_valid", rd_rsp_valid, exp_q.size() > 0);
            check_bit("req_ready", rd_req_ready, (exp_q.size() == 0) || rd_rsp_ready);
            if (exp_q.size() > 0) begin
                check("rsp_data", rd_rsp_data, exp_q[0]);
                if (rd_rsp_ready) begin
                    void'(exp_q.pop_front());
                    consumed++;
                end
            end
        end
    end

    task automatic cyc(input logic rv, input int ra, input logic rr,
                       input logic wv, input int wa,
                       input logic [WIDTH-1:0] wd, input logic [NUM_WORDS-1:0] we);
        rd_req_valid = rv;
        rd_addr      = LOG_NUM_ROWS'(ra);
        rd_rsp_ready = rr;
        wr_valid     = wv;
        wr_addr      = LOG_NUM_ROWS'(wa);
        wr_data      = wd;
        wr_en        = we;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 0, 1'b1, 1'b0, 0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] want;
        logic [WIDTH-1:0] row;
        int               c0;

        // Initial reset and reset-state checks.
        reset = 1'b1;
        idle();
        mon_on = 1'b1;
        idle();
        reset = 1'b0;
        check_bit("rst_valid", rd_rsp_valid, 1'b0);
        check("rst_data", rd_rsp_data, '0);

        // Preload row 5, reset again, then read it: must be zero.
        cyc(1'b0, 0, 1'b1, 1'b1, 5, rand_row() | 512'h1, '1);
        reset = 1'b1;
        idle();
        idle();
        reset = 1'b0;
        cyc(1'b1, 5, 1'b1, 1'b0, 0, '0, '0);
        check_bit("post_rst_valid", rd_rsp_valid, 1'b1);
        check("post_rst_read", rd_rsp_data, '0);
        idle();

        // Partial write of words 0 and 2, other lanes carry junk.
        row = rand_row();
        row[63:0]    = 64'hA;
        row[191:128] = 64'hC;
        cyc(1'b0, 0, 1'b1, 1'b1, 3, row, 8'b0000_0101);
        cyc(1'b1, 3, 1'b1, 1'b0, 0, '0, '0);
        want = '0;
        want[63:0]    = 64'hA;
        want[191:128] = 64'hC;
        check("partial_write", rd_rsp_data, want);
        idle();

        // Same-row bypass: row 7 all ones, read and write word 0 = 0 together.
        cyc(1'b0, 0, 1'b1, 1'b1, 7, '1, '1);
        row = rand_row();
        row[63:0] = '0;
        cyc(1'b1, 7, 1'b1, 1'b1, 7, row, 8'h01);
        want = '1;
        want[63:0] = '0;
        check("bypass", rd_rsp_data, want);
        idle();

        // Backpressure: reads 1,2,3 with a 3-cycle stall and a write to row 1.
        for (int a = 1; a <= 3; a++) cyc(1'b0, 0, 1'b1, 1'b1, a, rand_row(), '1);
        c0 = consumed;
        cyc(1'b1, 1, 1'b1, 1'b0, 0, '0, '0);
        cyc(1'b1, 2, 1'b0, 1'b1, 1, rand_row(), '1);
        cyc(1'b1, 2, 1'b0, 1'b0, 0, '0, '0);
        cyc(1'b1, 2, 1'b0, 1'b0, 0, '0, '0);
        cyc(1'b1, 2, 1'b1, 1'b0, 0, '0, '0);
        cyc(1'b1, 3, 1'b1, 1'b0, 0, '0, '0);
        idle();
        check("bp_count", WIDTH'(consumed - c0), WIDTH'(3));

        // Reset while a response is held.
        cyc(1'b0, 0, 1'b1, 1'b1, 9, rand_row() | 512'h1, '1);
        cyc(1'b1, 9, 1'b1, 1'b0, 0, '0, '0);
        cyc(1'b0, 0, 1'b0, 1'b0, 0, '0, '0);
        reset = 1'b1;
        cyc(1'b1, 9, 1'b0, 1'b1, 9, '1, '1);
        reset = 1'b0;
        check_bit("rst_drop_valid", rd_rsp_valid, 1'b0);
        cyc(1'b1, 9, 1'b1, 1'b0, 0, '0, '0);
        check("rst_row_zero", rd_rsp_data, '0);
        idle();

        // Streaming: 16 back-to-back reads with concurrent random writes.
        for (int a = 0; a < 16; a++) cyc(1'b0, 0, 1'b1, 1'b1, a, rand_row(), NUM_WORDS'($urandom));
        c0 = consumed;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, $urandom_range(0, 15), 1'b1, 1'($urandom_range(0, 1)),
                $urandom_range(0, 15), rand_row(), NUM_WORDS'($urandom));
            check_bit("stream_valid", rd_rsp_valid, 1'b1);
        end
        idle();
        check("stream_count", WIDTH'(consumed - c0), WIDTH'(16));

        // Random traffic on a few rows to force collisions, stalls and resets.
        for (int i = 0; i < 300; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            cyc(1'($urandom_range(0, 1)), $urandom_range(0, 7), ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), $urandom_range(0, 7), rand_row(), NUM_WORDS'($urandom));
        end
        reset = 1'b0;
        idle();
        idle();
        check_bit("drained", exp_q.size() == 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_1r1w_buffered.md
Name: sram_1r1w_buffered

Overview:
- Parametrised successor to the team's single-port-style SRAM.
- One read port with valid/ready request and response, one write port with per-word enables.
- Same-cycle read-after-write bypass, single-cycle logical reset via per-word valid bits (no row sweep).
- Sits behind cache and queue controllers that need backpressure-tolerant reads and an immediately usable array after reset.

Parameters:
WIDTH, 512, row width in bits
LOG_NUM_ROWS, 9, log2 of row count; NUM_ROWS = 2**LOG_NUM_ROWS
WORD_SIZE, 64, write-enable granularity in bits; WIDTH % WORD_SIZE == 0 required (elaboration-time assertion)
NUM_WORDS (local), WIDTH/WORD_SIZE, words per row

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
rd_req_valid  in  1  read request present
rd_req_ready  out  1  read request accepted this cycle when valid&ready
rd_addr  in  LOG_NUM_ROWS  read row address
rd_rsp_valid  out  1  response data valid
rd_rsp_ready  in  1  consumer accepts response
rd_rsp_data  out  WIDTH  read data
wr_valid  in  1  write present; always accepted
wr_addr  in  LOG_NUM_ROWS  write row address
wr_data  in  WIDTH  write data
wr_en  in  NUM_WORDS  per-word write enables; bit i covers bits [i*WORD_SIZE +: WORD_SIZE]

Behaviour:
- Reset: reset, synchronous, active-high; clock clk.
  - Reset clears every valid bit and rd_rsp_valid to 0.
  - rd_rsp_data resets to 0.
  - Data array is not cleared.
  - Writes and reads presented during reset are ignored.
- Valid bits:
  - One bit per (row, word).
  - An effective write sets the bit for each enabled word.
  - A word whose bit is 0 reads as all zeros.
- Write:
  - Effective when wr_valid && !reset.
  - Updates enabled words at the clock edge.
  - wr_valid with wr_en == 0 is a no-op.
- Read handshake:
  - rd_req_ready = !rd_rsp_valid || rd_rsp_ready (combinational; 1-entry output register, full throughput).
  - Accepted request in cycle N produces rd_rsp_valid = 1 with data in cycle N+1 (latency 1).
- Response hold:
  - While rd_rsp_valid && !rd_rsp_ready, rd_rsp_data and rd_rsp_valid hold stable.
  - Later writes to that row do not alter the held data.
- Response drain: if the response is consumed and no new request is accepted, rd_rsp_valid falls to 0 next cycle.
- Read/write same row, same cycle (write-first):
  - Response word i = wr_data word i if wr_en[i].
  - Otherwise the stored word, masked by its valid bit.
- Read/write different rows, same cycle: independent; no stall.
- Reset mid-operation:
  - A pending or held response is dropped (rd_rsp_valid = 0 next cycle).
  - All rows read as zero after reset deassertion until rewritten.
- No X on outputs:
  - rd_rsp_data is only updated on accept.
  - Masked words read as zeros, never as uninitialised array contents.

Decomposition:
- Package sram_pkg: word-mask merge function (old, new, en -> merged) and a valid-mask expand function (NUM_WORDS bits -> WIDTH mask).
- Sub-module sram_valid_table: NUM_ROWS x NUM_WORDS flop array with sync clear, set-on-write and a read port.
- Data array stays inline as a plain 1R1W memory so synthesis can infer RAM.

Test Plan:
- Post-reset read:
  - Stimulus: reset 2 cycles, then read addr 5.
  - Response: rd_rsp_valid one cycle later, rd_rsp_data == 0, even with non-zero data preloaded into the array before reset.
- Partial write:
  - Stimulus: write addr 3, wr_en = 8'b0000_0101, word0 = 64'hA, word2 = 64'hC; next cycle read addr 3.
  - Response: words 0 and 2 = A and C, all other words 0.
- Bypass:
  - Stimulus: row 7 holds all-ones; same cycle, read 7 and write 7 with wr_en = 8'h01, word0 = 0.
  - Response: word0 = 0, words 1..7 = all-ones.
- Backpressure:
  - Stimulus: reads of addrs 1, 2, 3 back-to-back; rd_rsp_ready low for 3 cycles after the first response; write addr 1 during the stall.
  - Response: rd_req_ready = 0 during the stall; response 1 holds the pre-write value; responses arrive in order 1, 2, 3 with none lost or duplicated.
- Reset mid-stall:
  - Stimulus: response held with rd_rsp_ready = 0, then reset asserted 1 cycle.
  - Response: rd_rsp_valid = 0 in the cycle after reset; a later read of the previously written row returns 0.
- Streaming throughput:
  - Stimulus: 16 consecutive reads with rd_rsp_ready = 1.
  - Response: 16 responses on 16 consecutive cycles, each matching a scoreboard model.
